// File: rtl/tt_uio_pkg.sv
// Shared types and defaults for the TinyTapeout uio bank.
// Contents: mode_e, the 2-bit per-pin mode; default parameter constants;
// sel_width(), which returns the channel-select width (at least 1 bit).
// Optional build macro UIO_EDGE_CNT_EN enables the per-channel edge counters.
package tt_uio_pkg;

  typedef enum logic [1:0] {
    MODE_TIE = 2'b00,
    MODE_IN  = 2'b01,
    MODE_OUT = 2'b10,
    MODE_DIV = 2'b11
  } mode_e;

  localparam int unsigned NCH_DEF         = 8;
  localparam int unsigned DIV_W_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W           = 8;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tt_uio_bank_if.sv
// Configuration write port of the uio bank (single-cycle write strobe).
// Signals: wr_en   write strobe, one cycle
//          wr_sel  target channel
//          wr_mode new mode (tt_uio_pkg::mode_e)
//          wr_val  OUT: bit0 = level; DIV: half-period reload
// Modports: master drives the port, slave is the bank.
interface tt_uio_bank_if #(
  parameter int unsigned NCH   = tt_uio_pkg::NCH_DEF,
  parameter int unsigned DIV_W = tt_uio_pkg::DIV_W_DEF
) ();

  localparam int unsigned SEL_W = tt_uio_pkg::sel_width(NCH);

  logic                  wr_en;
  logic [SEL_W-1:0]      wr_sel;
  tt_uio_pkg::mode_e     wr_mode;
  logic [DIV_W-1:0]      wr_val;

  modport master (output wr_en, wr_sel, wr_mode, wr_val);
  modport slave  (input  wr_en, wr_sel, wr_mode, wr_val);

endinterface

// File: rtl/tt_uio_chan.sv
// One uio pin channel: mode/value register, input synchroniser with
// rising-edge detect, half-period divider and (with UIO_EDGE_CNT_EN)
// an 8-bit rising-edge counter.
// Ports: clk, rst      clock, synchronous active-high reset
//        i_wr          write accepted for this channel
//        i_mode/i_val  write payload
//        i_pin         raw pad input
//        o_pin_out/o_pin_oe/o_in_sync/o_in_rise  registered pin outputs
//        o_cnt         edge counter (only with UIO_EDGE_CNT_EN)
module tt_uio_chan
  import tt_uio_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  mode_e            i_mode,
  input  logic [DIV_W-1:0] i_val,
  input  logic             i_pin,
  output logic             o_pin_out,
  output logic             o_pin_oe,
  output logic             o_in_sync,
  output logic             o_in_rise
`ifdef UIO_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  mode_e                  r_mode;
  logic [DIV_W-1:0]       r_val;
  logic [DIV_W-1:0]       r_div_cnt;
  logic                   r_phase;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pin_out;
  logic                   r_pin_oe;
  logic                   r_in_sync;
  logic                   r_in_rise;

  mode_e                  w_mode_nxt;
  logic [DIV_W-1:0]       w_val_nxt;
  logic [DIV_W-1:0]       w_div_cnt_nxt;
  logic                   w_phase_nxt;
  logic                   w_pin_out_nxt;
  logic                   w_pin_oe_nxt;
  logic                   w_in_nxt;
  logic                   w_in_sync_nxt;
  logic                   w_in_rise_nxt;

  // Next-state: a write reloads mode/value and restarts the divider phase.
  always_comb begin
    w_mode_nxt    = r_mode;
    w_val_nxt     = r_val;
    w_div_cnt_nxt = r_div_cnt;
    w_phase_nxt   = r_phase;
    w_pin_out_nxt = 1'b0;
    w_pin_oe_nxt  = 1'b0;

    if (i_wr) begin
      w_mode_nxt    = i_mode;
      w_val_nxt     = i_val;
      w_div_cnt_nxt = '0;
      w_phase_nxt   = 1'b0;
    end else if (r_mode == MODE_DIV) begin
      if (r_div_cnt == r_val) begin
        w_div_cnt_nxt = '0;
        w_phase_nxt   = ~r_phase;
      end else begin
        w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
      end
    end

    case (w_mode_nxt)
      MODE_OUT: begin
        w_pin_oe_nxt  = 1'b1;
        w_pin_out_nxt = w_val_nxt[0];
      end
      MODE_DIV: begin
        w_pin_oe_nxt  = 1'b1;
        w_pin_out_nxt = w_phase_nxt;
      end
      default: begin
        w_pin_oe_nxt  = 1'b0;
        w_pin_out_nxt = 1'b0;
      end
    endcase

    // r_in_sync mirrors the final synchroniser stage, gated to IN mode.
    // Rise needs IN both before and after the edge, so the first IN cycle
    // never pulses.
    w_in_nxt      = (w_mode_nxt == MODE_IN);
    w_in_sync_nxt = w_in_nxt & r_sync[SYNC_STAGES-2];
    w_in_rise_nxt = w_in_nxt & (r_mode == MODE_IN) &
                    r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
  end

  // State and output registers; the synchroniser shifts in every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= MODE_TIE;
      r_val     <= '0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_sync    <= '0;
      r_pin_out <= 1'b0;
      r_pin_oe  <= 1'b0;
      r_in_sync <= 1'b0;
      r_in_rise <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_val     <= w_val_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_pin_out <= w_pin_out_nxt;
      r_pin_oe  <= w_pin_oe_nxt;
      r_in_sync <= w_in_sync_nxt;
      r_in_rise <= w_in_rise_nxt;
    end
  end

  assign o_pin_out = r_pin_out;
  assign o_pin_oe  = r_pin_oe;
  assign o_in_sync = r_in_sync;
  assign o_in_rise = r_in_rise;

`ifdef UIO_EDGE_CNT_EN
  logic [CNT_W-1:0] r_edge_cnt;

  // Counts in_rise pulses, wrapping naturally; any write to the channel clears it.
  always_ff @(posedge clk) begin
    if (rst || i_wr) begin
      r_edge_cnt <= '0;
    end else if (w_in_rise_nxt) begin
      r_edge_cnt <= r_edge_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_edge_cnt;
`endif

endmodule

// File: rtl/tt_uio_bank.sv
// Parametrised bidirectional IO bank for the TinyTapeout uio pads.
// Each channel is TIE, IN (synchronised + rising edge), OUT or DIV.
// Ports: clk, rst      clock, synchronous active-high reset
//        cfg           configuration write port (tt_uio_bank_if.slave)
//        pin_in        from uio_in
//        pin_out       to uio_out
//        pin_oe        to uio_oe, 1 = drive
//        in_sync       synchronised pin_in (IN mode only)
//        in_rise       one-cycle rising-edge pulse (IN mode only)
//        rd_sel        edge-counter read select
//        rd_data       edge-counter read data, 1-cycle latency
// Build macro UIO_EDGE_CNT_EN adds per-channel edge counters; without it
// rd_data is tied to 0 and rd_sel is ignored.
module tt_uio_bank
  import tt_uio_pkg::*;
#(
  parameter int unsigned NCH         = NCH_DEF,
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  tt_uio_bank_if.slave              cfg,
  input  logic [NCH-1:0]            pin_in,
  output logic [NCH-1:0]            pin_out,
  output logic [NCH-1:0]            pin_oe,
  output logic [NCH-1:0]            in_sync,
  output logic [NCH-1:0]            in_rise,
  input  logic [sel_width(NCH)-1:0] rd_sel,
  output logic [CNT_W-1:0]          rd_data
);

  localparam int unsigned SEL_W = sel_width(NCH);

  logic [NCH-1:0] w_wr;

`ifdef UIO_EDGE_CNT_EN
  // Padded to the full select range so out-of-range selects read zero.
  logic [CNT_W-1:0] w_cnt_pad [2**SEL_W];
  logic [CNT_W-1:0] r_rd_data;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // Select values >= NCH match no channel, so such writes are dropped.
    assign w_wr[g] = cfg.wr_en && (cfg.wr_sel == SEL_W'(g));

    tt_uio_chan #(
      .DIV_W       (DIV_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr[g]),
      .i_mode    (cfg.wr_mode),
      .i_val     (cfg.wr_val),
      .i_pin     (pin_in[g]),
      .o_pin_out (pin_out[g]),
      .o_pin_oe  (pin_oe[g]),
      .o_in_sync (in_sync[g]),
      .o_in_rise (in_rise[g])
`ifdef UIO_EDGE_CNT_EN
      ,
      .o_cnt     (w_cnt_pad[g])
`endif
    );
  end

`ifdef UIO_EDGE_CNT_EN
  for (genvar g = NCH; g < (2**SEL_W); g++) begin : g_pad
    assign w_cnt_pad[g] = '0;
  end

  // Registered counter read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_cnt_pad[rd_sel];
    end
  end

  assign rd_data = r_rd_data;
`else
  logic w_unused_rd_sel;

  assign w_unused_rd_sel = ^rd_sel;
  assign rd_data         = '0;
`endif

endmodule

// File: tb/tb_tt_uio_bank.sv
// Directed bench for tt_uio_bank with a queue of expected values.
module tb_tt_uio_bank;
  import tt_uio_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 8 channels.
  tt_uio_bank_if #(.NCH(8), .DIV_W(8)) cfg8 ();
  logic [7:0] pin_in, pin_out, pin_oe, in_sync, in_rise;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;

  tt_uio_bank #(.NCH(8), .DIV_W(8), .SYNC_STAGES(2)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg8),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .in_sync (in_sync),
    .in_rise (in_rise),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

  // Second instance: 5 channels, so a 3-bit select can address past NCH.
  tt_uio_bank_if #(.NCH(5), .DIV_W(8)) cfg5 ();
  logic [4:0] pin_in5, pin_out5, pin_oe5, unused_sync5, unused_rise5;
  logic [2:0] rd_sel5;
  logic [7:0] unused_rd5;

  tt_uio_bank #(.NCH(5), .DIV_W(8), .SYNC_STAGES(2)) u_dut5 (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg5),
    .pin_in  (pin_in5),
    .pin_out (pin_out5),
    .pin_oe  (pin_oe5),
    .in_sync (unused_sync5),
    .in_rise (unused_rise5),
    .rd_sel  (rd_sel5),
    .rd_data (unused_rd5)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t x;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic wr8(input logic [2:0] sel, input mode_e m, input logic [7:0] v);
    cfg8.wr_en   = 1'b1;
    cfg8.wr_sel  = sel;
    cfg8.wr_mode = m;
    cfg8.wr_val  = v;
    step();
    cfg8.wr_en   = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] sel, input mode_e m, input logic [7:0] v);
    cfg5.wr_en   = 1'b1;
    cfg5.wr_sel  = sel;
    cfg5.wr_mode = m;
    cfg5.wr_val  = v;
    step();
    cfg5.wr_en   = 1'b0;
  endtask

  int n_rise;
  logic [7:0] exp_cnt;

  initial begin
    rst          = 1'b1;
    cfg8.wr_en   = 1'b0;
    cfg8.wr_sel  = '0;
    cfg8.wr_mode = MODE_TIE;
    cfg8.wr_val  = '0;
    cfg5.wr_en   = 1'b0;
    cfg5.wr_sel  = '0;
    cfg5.wr_mode = MODE_TIE;
    cfg5.wr_val  = '0;
    pin_in       = '0;
    pin_in5      = '0;
    rd_sel       = '0;
    rd_sel5      = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state with noisy pins, no writes.
    push("rst_rd_data", 8'h00);
    chk(rd_data);
    for (int i = 0; i < 20; i++) begin
      pin_in = 8'($urandom);
      step();
      push("rst_pin_oe", 8'h00);   chk(pin_oe);
      push("rst_pin_out", 8'h00);  chk(pin_out);
      push("rst_in_sync", 8'h00);  chk(in_sync);
      push("rst_in_rise", 8'h00);  chk(in_rise);
    end
    pin_in = '0;
    repeat (3) step();

    // Static output on ch3.
    push("out1_oe", 8'h08); push("out1_out", 8'h08);
    wr8(3'd3, MODE_OUT, 8'h01);
    chk(pin_oe); chk(pin_out);
    push("out0_oe", 8'h08); push("out0_out", 8'h00);
    wr8(3'd3, MODE_OUT, 8'hFE);
    chk(pin_oe); chk(pin_out);
    push("tie_oe", 8'h00); push("tie_out", 8'h00);
    wr8(3'd3, MODE_TIE, 8'h01);
    chk(pin_oe); chk(pin_out);

    // Input synchroniser and edge detect on ch0.
    wr8(3'd0, MODE_IN, 8'h00);
    push("in_mode_oe", 8'h00); chk(pin_oe);
    step();
    pin_in[0] = 1'b1;                      // cycle T
    push("in_t1_sync", 8'h00); push("in_t1_rise", 8'h00);
    step(); chk(in_sync); chk(in_rise);
    push("in_t2_sync", 8'h01); push("in_t2_rise", 8'h01);
    step(); chk(in_sync); chk(in_rise);
    push("in_t3_sync", 8'h01); push("in_t3_rise", 8'h00);
    step(); chk(in_sync); chk(in_rise);
    push("leave_in_sync", 8'h00); push("leave_in_rise", 8'h00);
    wr8(3'd0, MODE_TIE, 8'h00);
    chk(in_sync); chk(in_rise);
    // Re-entering IN with the pin already high: sync visible, no rise.
    push("reenter_sync", 8'h01); push("reenter_rise", 8'h00);
    wr8(3'd0, MODE_IN, 8'h00);
    chk(in_sync); chk(in_rise);
    push("reenter2_rise", 8'h00);
    step(); chk(in_rise);
    wr8(3'd0, MODE_TIE, 8'h00);
    pin_in[0] = 1'b0;

    // Divider on ch5: val=3 gives period 8, then val=0 restarts with period 2.
    wr8(3'd5, MODE_DIV, 8'd3);
    push("div_oe", 8'h20); chk(pin_oe);
    for (int k = 0; k < 6; k++) begin
      push($sformatf("div3_k%0d", k), 8'(((k / 4) % 2) << 5));
      chk(pin_out);
      step();
    end
    wr8(3'd5, MODE_DIV, 8'd0);
    for (int j = 0; j < 8; j++) begin
      push($sformatf("div0_j%0d", j), 8'((j % 2) << 5));
      chk(pin_out);
      step();
    end
    push("div_tie_oe", 8'h00);
    wr8(3'd5, MODE_TIE, 8'h00);
    chk(pin_oe);

    // Reset overrides a simultaneous write.
    push("pre_rst_oe", 8'h04);
    wr8(3'd2, MODE_OUT, 8'h01);
    chk(pin_oe);
    rst = 1'b1;
    push("rstwin_oe", 8'h00); push("rstwin_out", 8'h00);
    wr8(3'd4, MODE_OUT, 8'h01);
    rst = 1'b0;
    chk(pin_oe); chk(pin_out);
    push("rstwin2_oe", 8'h00);
    step(); chk(pin_oe);

    // Out-of-range selects on the 5-channel instance are ignored.
    push("sel6_oe", 8'h00);
    wr5(3'd6, MODE_OUT, 8'h01);
    chk(8'(pin_oe5));
    push("sel7_oe", 8'h00);
    wr5(3'd7, MODE_DIV, 8'h00);
    chk(8'(pin_oe5));
    push("sel4_oe", 8'h10); push("sel4_out", 8'h10);
    wr5(3'd4, MODE_OUT, 8'h01);
    chk(8'(pin_oe5)); chk(8'(pin_out5));

    // 257 rising edges on ch1.
    wr8(3'd1, MODE_IN, 8'h00);
    repeat (3) step();
    n_rise = 0;
    for (int e = 0; e < 257; e++) begin
      pin_in[1] = 1'b1;
      step(); if (in_rise[1]) n_rise++;
      step(); if (in_rise[1]) n_rise++;
      pin_in[1] = 1'b0;
      step(); if (in_rise[1]) n_rise++;
      step(); if (in_rise[1]) n_rise++;
    end
    repeat (3) begin
      step(); if (in_rise[1]) n_rise++;
    end
    push("rise_count", 8'(257 % 256));
    chk(8'(n_rise));
`ifdef UIO_EDGE_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    rd_sel = 3'd1;
    push("rd_cnt_ch1", exp_cnt);
    step(); chk(rd_data);
    rd_sel = 3'd0;
    push("rd_cnt_ch0", 8'h00);
    step(); chk(rd_data);
    rd_sel = 3'd1;
    wr8(3'd1, MODE_TIE, 8'h00);
    push("rd_cnt_cleared", 8'h00);
    step(); chk(rd_data);

    push("end_pin_oe", 8'h00);
    chk(pin_oe);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
